// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared types and constants for the register-file write-port
//            arbiter: completion-buffer entry layout and the x0 register id.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  // One buffered long-op result waiting for a free write-port cycle.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Bundles every non-clock/reset signal of the write-port arbiter.
// Ports    : master - pipeline/long-op side driving requests, reading results
//            slave  - the arbiter itself
//            kill, pipe_*, issue_*, lop_* (handshake), rs1_d/rs2_d/rd_d/
//            regwrite_d, stall_req, rf_we/rf_waddr/rf_wdata, busy
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;

  logic        kill;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        lop_valid;
  logic        lop_ready;
  logic [4:0]  lop_rd;
  logic [31:0] lop_wdata;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic        regwrite_d;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  modport master (
    output kill, pipe_we, pipe_rd, pipe_wdata, issue_valid, issue_rd,
           lop_valid, lop_rd, lop_wdata, rs1_d, rs2_d, rd_d, regwrite_d,
    input  lop_ready, stall_req, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  kill, pipe_we, pipe_rd, pipe_wdata, issue_valid, issue_rd,
           lop_valid, lop_rd, lop_wdata, rs1_d, rs2_d, rd_d, regwrite_d,
    output lop_ready, stall_req, rf_we, rf_waddr, rf_wdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Small completion buffer holding long-op results in arrival order.
// Ports    : clk, start (async active-low reset), clear (sync flush),
//            push/din, pop, head (current oldest entry), full, empty
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      start,
  input  wire logic      clear,
  input  wire logic      push,
  input  wire wb_entry_t din,
  input  wire logic      pop,
  output wb_entry_t      head,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  wb_entry_t   mem [DEPTH];
  // One extra pointer bit tells a full buffer apart from an empty one.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full  && !clear;
  assign do_pop  = pop  && !empty && !clear;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Shares the register-file write port between the in-order W stage
//            and out-of-order long-op completions. Buffers long-op results,
//            drains them into idle port cycles, tracks pending destinations
//            and requests ID stalls on hazards or buffer starvation.
// Ports    : clk, start (async active-low reset), bus (wb_arbiter_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input wire logic     clk,
  input wire logic     start,
  wb_arbiter_if.slave  bus
);

  localparam int            CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic [CW-1:0] starve_cnt;
  wb_entry_t     head;
  wb_entry_t     push_entry;
  logic          full;
  logic          empty;
  logic          w_owns;
  logic          drain;
  logic          starve;
  logic          hazard;

  // x0 writes from W are treated as idle so the buffer may use the port.
  assign w_owns = bus.pipe_we && (bus.pipe_rd != REG_ZERO);
  // A kill cycle performs no drain: the flushed entry must never be written.
  assign drain  = start && !bus.kill && !w_owns && !empty;

  assign push_entry.rd    = bus.lop_rd;
  assign push_entry.wdata = bus.lop_wdata;

  wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .start (start),
    .clear (bus.kill),
    .push  (bus.lop_valid),
    .din   (push_entry),
    .pop   (drain),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = REG_ZERO;
    bus.rf_wdata = '0;
    if (w_owns && start) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.pipe_rd;
      bus.rf_wdata = bus.pipe_wdata;
    end else if (drain) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head.rd;
      bus.rf_wdata = head.wdata;
    end
  end

  // Clear applied before set so an issue to the register being drained wins.
  always_comb begin
    pending_nxt = pending;
    if (drain) pending_nxt[head.rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != REG_ZERO))
      pending_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      pending <= '0;
    end else if (bus.kill) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Counts consecutive cycles in which a buffered result lost the port to W.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      starve_cnt <= '0;
    end else if (bus.kill || empty || drain) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_ONE;
    end
  end

  assign starve = (starve_cnt == STARVE_MAX);

  assign hazard = ((bus.rs1_d != REG_ZERO) && pending[bus.rs1_d]) ||
                  ((bus.rs2_d != REG_ZERO) && pending[bus.rs2_d]) ||
                  (bus.regwrite_d && (bus.rd_d != REG_ZERO) && pending[bus.rd_d]);

  assign bus.stall_req = start && (hazard || starve);
  assign bus.lop_ready = start && !full;
  assign bus.busy      = start && ((|pending) || !empty);

  // A second issue to a register whose result is still outstanding is illegal.
  a_issue_not_pending : assert property (
    @(posedge clk) disable iff (!start)
    (bus.issue_valid && !bus.kill && (bus.issue_rd != REG_ZERO)) |-> !pending[bus.issue_rd]
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter: directed scenarios followed by
//            randomized traffic, compared against a queue-based reference model.
// Ports    : (none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  // Reference model state
  bit [31:0] m_pend;
  wb_entry_t m_q[$];
  int        m_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_q.delete();
    m_cnt = 0;
  endtask

  task automatic idle();
    bus.kill        = 1'b0;
    bus.pipe_we     = 1'b0;
    bus.pipe_rd     = 5'd0;
    bus.pipe_wdata  = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.lop_valid   = 1'b0;
    bus.lop_rd      = 5'd0;
    bus.lop_wdata   = 32'd0;
    bus.rs1_d       = 5'd0;
    bus.rs2_d       = 5'd0;
    bus.rd_d        = 5'd0;
    bus.regwrite_d  = 1'b0;
  endtask

  // Called just after a falling edge with inputs already applied: checks all
  // outputs against the model, then advances the model across the rising edge.
  task automatic cycle();
    logic        w_own;
    logic        drain;
    logic        was_empty;
    logic [31:0] e_we, e_addr, e_data, e_stall, e_ready, e_busy;
    wb_entry_t   ent;
    #1;
    e_we = 0; e_addr = 0; e_data = 0; e_stall = 0; e_ready = 0; e_busy = 0;
    drain = 1'b0;
    w_own = bus.pipe_we && (bus.pipe_rd != 5'd0);
    if (start) begin
      drain = !w_own && (m_q.size() != 0) && !bus.kill;
      if (w_own) begin
        e_we = 1; e_addr = 32'(bus.pipe_rd); e_data = bus.pipe_wdata;
      end else if (drain) begin
        e_we = 1; e_addr = 32'(m_q[0].rd); e_data = m_q[0].wdata;
      end
      e_ready = 32'(m_q.size() < DEPTH);
      e_busy  = 32'((m_pend != 0) || (m_q.size() != 0));
      e_stall = 32'(((bus.rs1_d != 0) && m_pend[bus.rs1_d]) ||
                    ((bus.rs2_d != 0) && m_pend[bus.rs2_d]) ||
                    (bus.regwrite_d && (bus.rd_d != 0) && m_pend[bus.rd_d]) ||
                    (m_cnt == LIMIT));
    end
    check("rf_we",     32'(bus.rf_we),     e_we);
    check("rf_waddr",  32'(bus.rf_waddr),  e_addr);
    check("rf_wdata",  bus.rf_wdata,       e_data);
    check("stall_req", 32'(bus.stall_req), e_stall);
    check("lop_ready", 32'(bus.lop_ready), e_ready);
    check("busy",      32'(bus.busy),      e_busy);
    @(posedge clk);
    if (!start || bus.kill) begin
      model_reset();
    end else begin
      was_empty = (m_q.size() == 0);
      if (drain) begin
        m_pend[m_q[0].rd] = 1'b0;
        void'(m_q.pop_front());
      end
      if (bus.issue_valid && (bus.issue_rd != 0)) m_pend[bus.issue_rd] = 1'b1;
      if (bus.lop_valid && e_ready[0]) begin
        ent.rd = bus.lop_rd;
        ent.wdata = bus.lop_wdata;
        m_q.push_back(ent);
      end
      if (was_empty || drain) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    int r;
    int phase;
    idle();
    model_reset();
    @(negedge clk);
    // Reset state
    cycle();
    cycle();
    start = 1'b1;

    // x5: issue, complete with 0xDEAD, drain next cycle, stall drops after
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; cycle();
    idle(); bus.lop_valid = 1'b1; bus.lop_rd = 5'd5; bus.lop_wdata = 32'hDEAD; bus.rs1_d = 5'd5; cycle();
    idle(); bus.rs1_d = 5'd5; cycle();
    idle(); bus.rs1_d = 5'd5; cycle();

    // x7: RAW on rs2, x0 never stalls, WAW on rd, then drain releases
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; cycle();
    idle(); bus.rs2_d = 5'd7; cycle();
    idle(); bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; cycle();
    idle(); bus.regwrite_d = 1'b1; bus.rd_d = 5'd7; cycle();
    idle(); bus.lop_valid = 1'b1; bus.lop_rd = 5'd7; bus.lop_wdata = 32'h7777; bus.rs2_d = 5'd7; cycle();
    idle(); bus.rs2_d = 5'd7; cycle();
    idle(); bus.rs2_d = 5'd7; cycle();

    // x9 starved by W writing x3 every cycle, then released
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; cycle();
    idle(); bus.lop_valid = 1'b1; bus.lop_rd = 5'd9; bus.lop_wdata = 32'h9999;
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h3333; cycle();
    for (int i = 0; i < 6; i++) begin
      idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h3000 + i; cycle();
    end
    idle(); cycle();
    idle(); cycle();

    // Fill buffer while W is busy, hold a third result, then drain in order
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd1; cycle();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd2; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd8; bus.lop_valid = 1'b1; bus.lop_rd = 5'd1; bus.lop_wdata = 32'h1111; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd8; bus.lop_valid = 1'b1; bus.lop_rd = 5'd2; bus.lop_wdata = 32'h2222; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd8; bus.lop_valid = 1'b1; bus.lop_rd = 5'd12; bus.lop_wdata = 32'hCCCC; cycle();
    idle(); bus.lop_valid = 1'b1; bus.lop_rd = 5'd12; bus.lop_wdata = 32'hCCCC; cycle();
    idle(); bus.lop_valid = 1'b1; bus.lop_rd = 5'd12; bus.lop_wdata = 32'hCCCC; cycle();
    for (int i = 0; i < 3; i++) begin idle(); cycle(); end

    // Kill with one buffered entry and x4/x6 pending
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; cycle();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.lop_valid = 1'b1; bus.lop_rd = 5'd4; bus.lop_wdata = 32'h4444; cycle();
    idle(); bus.kill = 1'b1; bus.rs1_d = 5'd4; cycle();
    idle(); bus.rs1_d = 5'd4; bus.rs2_d = 5'd6; cycle();
    idle(); cycle();

    // Asynchronous reset mid-operation
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.lop_valid = 1'b1; bus.lop_rd = 5'd10; bus.lop_wdata = 32'hAAAA; cycle();
    idle(); bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h5; bus.rs1_d = 5'd10;
    #2 start = 1'b0;
    #1;
    check("async_rf_we",     32'(bus.rf_we),     32'd0);
    check("async_rf_waddr",  32'(bus.rf_waddr),  32'd0);
    check("async_rf_wdata",  bus.rf_wdata,       32'd0);
    check("async_stall_req", 32'(bus.stall_req), 32'd0);
    check("async_lop_ready", 32'(bus.lop_ready), 32'd0);
    check("async_busy",      32'(bus.busy),      32'd0);
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    start = 1'b1;

    // Randomized traffic, alternating heavy- and light-W phases
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 40) % 3;
      idle();
      bus.pipe_we    = ($urandom_range(0, 99) < ((phase == 0) ? 90 : 30));
      bus.pipe_rd    = 5'($urandom_range(0, 31));
      bus.pipe_wdata = $urandom;
      bus.kill       = ($urandom_range(0, 99) == 0);
      if (!bus.kill && ($urandom_range(0, 2) == 0)) begin
        r = $urandom_range(0, 31);
        if (r == 0 || !m_pend[r]) begin
          bus.issue_valid = 1'b1;
          bus.issue_rd    = 5'(r);
        end
      end
      bus.lop_valid = 1'($urandom_range(0, 1));
      bus.lop_wdata = $urandom;
      r = $urandom_range(1, 31);
      bus.lop_rd = 5'(r);
      for (int k = 0; k < 32; k++) begin
        if (m_pend[(r + k) % 32]) begin
          bus.lop_rd = 5'((r + k) % 32);
          break;
        end
      end
      bus.rs1_d      = 5'($urandom_range(0, 31));
      bus.rs2_d      = 5'($urandom_range(0, 31));
      bus.rd_d       = 5'($urandom_range(0, 31));
      bus.regwrite_d = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
